// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings and constants for the MIPS fetch pipeline
package pipe_pkg;

   typedef enum logic [1:0] {
      S_ISSUE = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2
   } fetch_state_e;

   localparam logic [31:0] P_NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] P_RESET_PC  = 32'h0000_3000;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bus
interface fetch_stage_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage with PC, one-outstanding imem fetch and IF/ID register
module fetch_stage
   import pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = P_RESET_PC,
   parameter logic [31:0] NOP_INSTR = P_NOP_INSTR
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 Stall_IF,
   input  logic                 Stall_ID,
   input  logic                 ID_PCSrc,
   input  logic [31:0]          ID_Target,
   fetch_stage_if.master        imem,
   output logic [31:0]          IF_ID_Instr,
   output logic [31:0]          IF_ID_PC4,
   output logic                 IF_ID_Valid,
   output logic                 IF_Wait
);

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;

   logic [31:0] r_pc;
   logic        r_kill;
   logic [31:0] r_hold;
   logic [31:0] r_ifid_instr;
   logic [31:0] r_ifid_pc4;
   logic        r_ifid_valid;

   logic [31:0] w_pc_nxt;
   logic [31:0] w_pc_inc;
   logic [31:0] w_target;
   logic        w_kill_nxt;
   logic [31:0] w_hold_nxt;
   logic        w_deliver;
   logic [31:0] w_deliver_instr;
   logic        w_stall;
   logic        w_redir;

   // Redirects are only trusted when ID is not stalled; stalled operands may be stale.
   assign w_stall  = Stall_IF | Stall_ID;
   assign w_redir  = ID_PCSrc & ~w_stall;
   assign w_pc_inc = r_pc + 32'd4;
   assign w_target = word_align(ID_Target);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_ISSUE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_kill_nxt      = r_kill;
      w_hold_nxt      = r_hold;
      w_deliver       = 1'b0;
      w_deliver_instr = r_hold;
      case (r_state)
         S_ISSUE: begin
            w_state_nxt = S_WAIT;
            if (w_redir) begin
               w_pc_nxt   = w_target;
               w_kill_nxt = 1'b1;
            end
         end
         S_WAIT: begin
            if (!imem.imem_rvalid) begin
               if (w_redir) begin
                  w_pc_nxt   = w_target;
                  w_kill_nxt = 1'b1;
               end
            end else if (r_kill || w_redir) begin
               w_kill_nxt  = 1'b0;
               w_state_nxt = S_ISSUE;
               if (w_redir) begin
                  w_pc_nxt = w_target;
               end
            end else if (!w_stall) begin
               w_deliver       = 1'b1;
               w_deliver_instr = imem.imem_rdata;
               w_pc_nxt        = w_pc_inc;
               w_state_nxt     = S_ISSUE;
            end else begin
               w_hold_nxt  = imem.imem_rdata;
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (!w_stall) begin
               w_state_nxt = S_ISSUE;
               if (w_redir) begin
                  w_pc_nxt = w_target;
               end else begin
                  w_deliver = 1'b1;
                  w_pc_nxt  = w_pc_inc;
               end
            end
         end
         default: begin
            w_state_nxt = S_ISSUE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc         <= RESET_PC;
         r_kill       <= 1'b0;
         r_hold       <= 32'd0;
         r_ifid_instr <= NOP_INSTR;
         r_ifid_pc4   <= 32'd0;
         r_ifid_valid <= 1'b0;
      end else begin
         r_pc   <= w_pc_nxt;
         r_kill <= w_kill_nxt;
         r_hold <= w_hold_nxt;
         // Anything other than a delivery while unstalled becomes a bubble, including redirect squash.
         if (!w_stall) begin
            if (w_deliver) begin
               r_ifid_instr <= w_deliver_instr;
               r_ifid_pc4   <= w_pc_inc;
               r_ifid_valid <= 1'b1;
            end else begin
               r_ifid_instr <= NOP_INSTR;
               r_ifid_pc4   <= 32'd0;
               r_ifid_valid <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      imem.imem_req  = (r_state == S_ISSUE) & ~rst;
      imem.imem_addr = word_align(r_pc);
      IF_Wait        = ~((r_state == S_HOLD) ||
                         ((r_state == S_WAIT) && imem.imem_rvalid && !r_kill));
   end

   assign IF_ID_Instr = r_ifid_instr;
   assign IF_ID_PC4   = r_ifid_pc4;
   assign IF_ID_Valid = r_ifid_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        Stall_IF;
   logic        Stall_ID;
   logic        ID_PCSrc;
   logic [31:0] ID_Target;
   logic [31:0] IF_ID_Instr;
   logic [31:0] IF_ID_PC4;
   logic        IF_ID_Valid;
   logic        IF_Wait;

   int n_pass;
   int n_total;

   fetch_stage_if bus ();

   fetch_stage dut (
      .clk         (clk),
      .rst         (rst),
      .Stall_IF    (Stall_IF),
      .Stall_ID    (Stall_ID),
      .ID_PCSrc    (ID_PCSrc),
      .ID_Target   (ID_Target),
      .imem        (bus.master),
      .IF_ID_Instr (IF_ID_Instr),
      .IF_ID_PC4   (IF_ID_PC4),
      .IF_ID_Valid (IF_ID_Valid),
      .IF_Wait     (IF_Wait)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_stall(input logic s);
      Stall_IF = s;
      Stall_ID = s;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_stall(1'b0);
      ID_PCSrc = 1'b0;
      ID_Target = 32'd0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = 32'd0;
      tick();
      tick();
      n_total++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", bus.imem_req); else n_pass++;
      n_total++; if (IF_ID_Instr !== 32'h0) $display("FAIL reset_instr got %h want 00000000", IF_ID_Instr); else n_pass++;
      n_total++; if (IF_ID_PC4 !== 32'h0) $display("FAIL reset_pc4 got %h want 00000000", IF_ID_PC4); else n_pass++;
      n_total++; if (IF_ID_Valid !== 1'b0) $display("FAIL reset_valid got %b want 0", IF_ID_Valid); else n_pass++;
      rst = 1'b0;
      #1;
      n_total++; if (bus.imem_req !== 1'b1) $display("FAIL release_req got %b want 1", bus.imem_req); else n_pass++;
      n_total++; if (bus.imem_addr !== 32'h3000) $display("FAIL release_addr got %h want 00003000", bus.imem_addr); else n_pass++;
   endtask

   task automatic test_first_fetch();
      tick();
      n_total++; if (bus.imem_req !== 1'b0) $display("FAIL wait_req got %b want 0", bus.imem_req); else n_pass++;
      n_total++; if (IF_Wait !== 1'b1) $display("FAIL wait_ifwait got %b want 1", IF_Wait); else n_pass++;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'h2401_0005;
      #1;
      n_total++; if (IF_Wait !== 1'b0) $display("FAIL rvalid_ifwait got %b want 0", IF_Wait); else n_pass++;
      tick();
      bus.imem_rvalid = 1'b0;
      n_total++; if (IF_ID_Instr !== 32'h2401_0005) $display("FAIL first_instr got %h want 24010005", IF_ID_Instr); else n_pass++;
      n_total++; if (IF_ID_PC4 !== 32'h3004) $display("FAIL first_pc4 got %h want 00003004", IF_ID_PC4); else n_pass++;
      n_total++; if (IF_ID_Valid !== 1'b1) $display("FAIL first_valid got %b want 1", IF_ID_Valid); else n_pass++;
      n_total++; if (bus.imem_addr !== 32'h3004 || bus.imem_req !== 1'b1) $display("FAIL next_addr got %h req %b want 00003004 req 1", bus.imem_addr, bus.imem_req); else n_pass++;
   endtask

   task automatic test_stall_hold();
      set_stall(1'b1);
      tick();
      n_total++; if (IF_ID_Instr !== 32'h2401_0005 || IF_ID_Valid !== 1'b1) $display("FAIL stall_held got %h/%b want 24010005/1", IF_ID_Instr, IF_ID_Valid); else n_pass++;
      ID_PCSrc = 1'b1;
      ID_Target = 32'h5000;
      tick();
      ID_PCSrc = 1'b0;
      n_total++; if (bus.imem_req !== 1'b0 || IF_ID_Instr !== 32'h2401_0005) $display("FAIL stalled_redir_ignored req %b instr %h want 0/24010005", bus.imem_req, IF_ID_Instr); else n_pass++;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'h8C22_0010;
      #1;
      n_total++; if (IF_Wait !== 1'b0) $display("FAIL stalled_no_kill ifwait got %b want 0", IF_Wait); else n_pass++;
      tick();
      bus.imem_rvalid = 1'b0;
      #1;
      n_total++; if (IF_Wait !== 1'b0 || bus.imem_req !== 1'b0) $display("FAIL hold_state ifwait %b req %b want 0/0", IF_Wait, bus.imem_req); else n_pass++;
      n_total++; if (IF_ID_Instr !== 32'h2401_0005) $display("FAIL hold_ifid got %h want 24010005", IF_ID_Instr); else n_pass++;
      tick();
      set_stall(1'b0);
      tick();
      n_total++; if (IF_ID_Instr !== 32'h8C22_0010) $display("FAIL hold_release_instr got %h want 8c220010", IF_ID_Instr); else n_pass++;
      n_total++; if (IF_ID_PC4 !== 32'h3008 || IF_ID_Valid !== 1'b1) $display("FAIL hold_release_pc4 got %h/%b want 00003008/1", IF_ID_PC4, IF_ID_Valid); else n_pass++;
      n_total++; if (bus.imem_addr !== 32'h3008 || bus.imem_req !== 1'b1) $display("FAIL hold_next_addr got %h req %b want 00003008 req 1", bus.imem_addr, bus.imem_req); else n_pass++;
   endtask

   task automatic test_redirect_wait();
      tick();
      n_total++; if (IF_ID_Valid !== 1'b0 || IF_ID_Instr !== 32'h0) $display("FAIL bubble got %h/%b want 00000000/0", IF_ID_Instr, IF_ID_Valid); else n_pass++;
      ID_PCSrc = 1'b1;
      ID_Target = 32'h3103;
      tick();
      ID_PCSrc = 1'b0;
      tick();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      #1;
      n_total++; if (IF_Wait !== 1'b1) $display("FAIL killed_ifwait got %b want 1", IF_Wait); else n_pass++;
      tick();
      bus.imem_rvalid = 1'b0;
      n_total++; if (IF_ID_Valid !== 1'b0 || IF_ID_Instr !== 32'h0) $display("FAIL killed_discard got %h/%b want 00000000/0", IF_ID_Instr, IF_ID_Valid); else n_pass++;
      n_total++; if (bus.imem_addr !== 32'h3100 || bus.imem_req !== 1'b1) $display("FAIL redir_addr got %h req %b want 00003100 req 1", bus.imem_addr, bus.imem_req); else n_pass++;
   endtask

   task automatic test_redirect_with_rvalid();
      tick();
      ID_PCSrc = 1'b1;
      ID_Target = 32'h3200;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'h1111_1111;
      tick();
      ID_PCSrc = 1'b0;
      bus.imem_rvalid = 1'b0;
      n_total++; if (IF_ID_Valid !== 1'b0) $display("FAIL same_cycle_discard valid got %b want 0", IF_ID_Valid); else n_pass++;
      n_total++; if (bus.imem_addr !== 32'h3200 || bus.imem_req !== 1'b1) $display("FAIL same_cycle_addr got %h req %b want 00003200 req 1", bus.imem_addr, bus.imem_req); else n_pass++;
      tick();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'h2222_2222;
      #1;
      n_total++; if (IF_Wait !== 1'b0) $display("FAIL same_cycle_kill_clear ifwait got %b want 0", IF_Wait); else n_pass++;
      tick();
      bus.imem_rvalid = 1'b0;
      n_total++; if (IF_ID_Instr !== 32'h2222_2222 || IF_ID_PC4 !== 32'h3204) $display("FAIL after_redir_fetch got %h/%h want 22222222/00003204", IF_ID_Instr, IF_ID_PC4); else n_pass++;
   endtask

   task automatic test_wrap();
      ID_PCSrc = 1'b1;
      ID_Target = 32'hFFFF_FFFC;
      tick();
      ID_PCSrc = 1'b0;
      n_total++; if (IF_ID_Valid !== 1'b0) $display("FAIL issue_redir_squash valid got %b want 0", IF_ID_Valid); else n_pass++;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'h0000_0BAD;
      tick();
      bus.imem_rvalid = 1'b0;
      n_total++; if (bus.imem_addr !== 32'hFFFF_FFFC || IF_ID_Valid !== 1'b0) $display("FAIL wrap_addr got %h valid %b want fffffffc valid 0", bus.imem_addr, IF_ID_Valid); else n_pass++;
      tick();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'h3333_3333;
      tick();
      bus.imem_rvalid = 1'b0;
      n_total++; if (IF_ID_PC4 !== 32'h0 || IF_ID_Instr !== 32'h3333_3333 || IF_ID_Valid !== 1'b1) $display("FAIL wrap_pc4 got %h/%h/%b want 00000000/33333333/1", IF_ID_PC4, IF_ID_Instr, IF_ID_Valid); else n_pass++;
      n_total++; if (bus.imem_addr !== 32'h0) $display("FAIL wrap_next_addr got %h want 00000000", bus.imem_addr); else n_pass++;
   endtask

   task automatic test_reset_in_hold();
      set_stall(1'b1);
      tick();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 32'h4444_4444;
      tick();
      bus.imem_rvalid = 1'b0;
      #1;
      n_total++; if (IF_Wait !== 1'b0 || IF_ID_Valid !== 1'b1) $display("FAIL pre_reset_hold ifwait %b valid %b want 0/1", IF_Wait, IF_ID_Valid); else n_pass++;
      #1;
      rst = 1'b1;
      #1;
      n_total++; if (bus.imem_req !== 1'b0 || IF_Wait !== 1'b1) $display("FAIL async_reset_req req %b ifwait %b want 0/1", bus.imem_req, IF_Wait); else n_pass++;
      n_total++; if (IF_ID_Instr !== 32'h0 || IF_ID_PC4 !== 32'h0 || IF_ID_Valid !== 1'b0) $display("FAIL async_reset_ifid got %h/%h/%b want 00000000/00000000/0", IF_ID_Instr, IF_ID_PC4, IF_ID_Valid); else n_pass++;
      n_total++; if (bus.imem_addr !== 32'h3000) $display("FAIL async_reset_addr got %h want 00003000", bus.imem_addr); else n_pass++;
      set_stall(1'b0);
      tick();
      rst = 1'b0;
      #1;
      n_total++; if (bus.imem_req !== 1'b1) $display("FAIL post_reset_req got %b want 1", bus.imem_req); else n_pass++;
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      test_reset();
      test_first_fetch();
      test_stall_hold();
      test_redirect_wait();
      test_redirect_with_rvalid();
      test_wrap();
      test_reset_in_hold();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
